// File: rtl/fifo_axi_pkg.sv
// Shared defaults for the frame-buffering FIFO: data/address/counter widths,
// the default low output watermark and a helper that derives DEPTH from AW.
package fifo_axi_pkg;

   localparam int unsigned DW_DEF     = 512;
   localparam int unsigned AW_DEF     = 5;
   localparam int unsigned FW_DEF     = 16;
   localparam int unsigned OL_LIM_DEF = 4;

   // Number of storage entries for a given address width
   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'(1) << aw;
   endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Registered-read dual-pointer RAM FIFO core.
// Ports:
//   clk, rst_n, clr  clock, synchronous active-low reset, synchronous clear
//   wr_en, din       write strobe and data (ignored while full)
//   rd_en            read strobe (ignored while empty)
//   valid, dout      read data and its valid flag, one cycle after rd_en
//   cnt              occupancy 0..DEPTH
//   full, empty      combinational occupancy flags
module fifo_sync_ram
   import fifo_axi_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [DW-1:0] din,
   input  logic          rd_en,
   output logic          valid,
   output logic [DW-1:0] dout,
   output logic [AW:0]   cnt,
   output logic          full,
   output logic          empty
);

   localparam int unsigned DEPTH = depth_of(AW);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          wr_ok, rd_ok;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   // Pointer, occupancy and read-port next state; pointers wrap mod DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         dout_d   = mem_q[rd_ptr_q];
         valid_d  = 1'b1;
      end
      case ({wr_ok, rd_ok})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
      end
   end

   // Storage has no reset; stale contents are never read back
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= din;
   end

   assign cnt   = cnt_q;
   assign dout  = dout_q;
   assign valid = valid_q;

endmodule

// File: rtl/fifo_axi_frm.sv
// Frame-buffering FIFO between the AXI data mover and the local datapath.
// Holds one frame; watermark-throttled irdy/ordy, end-of-frame flush with
// last-word marking, frame length capture and frame-done pulse.
// Ports:
//   clk, rst_n, clr   clock, synchronous active-low reset, synchronous clear
//   iend, den, din    frame end, write strobe, write data
//   irdy              registered input-ready watermark flag
//   rdrq              read request
//   ordy              registered output-ready watermark flag
//   dout, dv          read data and valid, one cycle after an accepted rdrq
//   olast             comb: current rdrq takes the last word of the frame
//   empty, full, cnt  occupancy (empty/full combinational)
//   flush             frame fully written, draining
//   flen              frame length latched at iend
//   fdone             one-cycle frame-complete pulse
//   ovfl, udfl        sticky overflow / underflow errors
module fifo_axi_frm
   import fifo_axi_pkg::*;
#(
   parameter int unsigned DW     = DW_DEF,
   parameter int unsigned AW     = AW_DEF,
   parameter int unsigned FW     = FW_DEF,
   parameter int unsigned IH_LIM = depth_of(AW) - 4,
   parameter int unsigned IL_LIM = depth_of(AW) / 2,
   parameter int unsigned OH_LIM = depth_of(AW) / 2,
   parameter int unsigned OL_LIM = OL_LIM_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          iend,
   input  logic          den,
   input  logic [DW-1:0] din,
   output logic          irdy,
   input  logic          rdrq,
   output logic          ordy,
   output logic [DW-1:0] dout,
   output logic          dv,
   output logic          olast,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   cnt,
   output logic          flush,
   output logic [FW-1:0] flen,
   output logic          fdone,
   output logic          ovfl,
   output logic          udfl
);

   localparam logic [AW:0] IH_C = (AW+1)'(IH_LIM);
   localparam logic [AW:0] IL_C = (AW+1)'(IL_LIM);
   localparam logic [AW:0] OH_C = (AW+1)'(OH_LIM);
   localparam logic [AW:0] OL_C = (AW+1)'(OL_LIM);

   logic [FW-1:0] i_cnt_q, i_cnt_d;
   logic [FW-1:0] o_cnt_q, o_cnt_d;
   logic [FW-1:0] flen_q, flen_d;
   logic          flush_q, flush_d;
   logic          fdone_q, fdone_d;
   logic          irdy_q, irdy_d;
   logic          ordy_q, ordy_d;
   logic          ovfl_q, ovfl_d;
   logic          udfl_q, udfl_d;
   logic          wr_acc, rd_acc, frm_empty_end;

   // Writes are locked out while the current frame drains
   assign wr_acc        = den & ~full & ~flush_q;
   assign rd_acc        = rdrq & ~empty;
   assign olast         = rdrq & flush_q & (o_cnt_q == (i_cnt_q - FW'(1)));
   assign frm_empty_end = flush_q & (i_cnt_q == '0);

   fifo_sync_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .wr_en (wr_acc),
      .din   (din),
      .rd_en (rd_acc),
      .valid (dv),
      .dout  (dout),
      .cnt   (cnt),
      .full  (full),
      .empty (empty)
   );

   // Frame counters, flush/fdone, watermarks and error flags
   always_comb begin
      i_cnt_d = i_cnt_q;
      o_cnt_d = o_cnt_q;
      flen_d  = flen_q;
      flush_d = flush_q;
      fdone_d = olast | frm_empty_end;
      irdy_d  = irdy_q;
      ordy_d  = ordy_q;
      ovfl_d  = ovfl_q | (den & ~wr_acc);
      udfl_d  = udfl_q | (rdrq & empty);

      // Counters restart at frame end; a transfer in the fdone cycle counts
      if (olast) begin
         i_cnt_d = '0;
         o_cnt_d = '0;
      end else if (fdone_q) begin
         i_cnt_d = FW'(wr_acc);
         o_cnt_d = FW'(rd_acc);
      end else begin
         if (wr_acc) i_cnt_d = i_cnt_q + FW'(1);
         if (rd_acc) o_cnt_d = o_cnt_q + FW'(1);
      end

      // Length includes a word written in the same cycle as iend
      if (flush_q) begin
         if (olast || frm_empty_end) flush_d = 1'b0;
      end else if (iend) begin
         flush_d = 1'b1;
         flen_d  = i_cnt_d;
      end

      if (flush_q || iend)  irdy_d = 1'b0;
      else if (cnt <= IL_C) irdy_d = 1'b1;
      else if (cnt >= IH_C) irdy_d = 1'b0;

      if (flush_q)          ordy_d = ~olast;
      else if (cnt <= OL_C) ordy_d = 1'b0;
      else if (cnt >= OH_C) ordy_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         i_cnt_q <= '0;
         o_cnt_q <= '0;
         flen_q  <= '0;
         flush_q <= 1'b0;
         fdone_q <= 1'b0;
         irdy_q  <= 1'b0;
         ordy_q  <= 1'b0;
         ovfl_q  <= 1'b0;
         udfl_q  <= 1'b0;
      end else begin
         i_cnt_q <= i_cnt_d;
         o_cnt_q <= o_cnt_d;
         flen_q  <= flen_d;
         flush_q <= flush_d;
         fdone_q <= fdone_d;
         irdy_q  <= irdy_d;
         ordy_q  <= ordy_d;
         ovfl_q  <= ovfl_d;
         udfl_q  <= udfl_d;
      end
   end

   assign irdy  = irdy_q;
   assign ordy  = ordy_q;
   assign flush = flush_q;
   assign flen  = flen_q;
   assign fdone = fdone_q;
   assign ovfl  = ovfl_q;
   assign udfl  = udfl_q;

endmodule
